vu_sample_ctrl: RTL and testbench

Sequencer for the 8-bit sample holding register in the VU-meter datapath. It divides the system clock into a periodic sample tick and runs a start/ready handshake with the ADC front end. It then drives the holding register's `enable`, `load` and `error` strobes so that only good conversions are captured. It also keeps sticky status for timeouts, faults and tick overruns.

---
 rtl/vu_pkg.sv | 17 +
 rtl/vu_tick_gen.sv | 35 +++
 rtl/vu_sample_ctrl.sv | 126 ++++++++++++
 tb/tb_vu_sample_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vu_pkg.sv
// Shared types and defaults for the VU-meter sample path.
// Holds the sequencer state enum and width/default constants.
package vu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_START     = 3'd2,
    ST_CONVERT   = 3'd3,
    ST_LOAD      = 3'd4
  } vu_ctrl_state_t;

  localparam int VU_ERR_CNT_W   = 8;
  localparam int VU_SAMPLE_DIV  = 1000;
  localparam int VU_ADC_TIMEOUT = 64;

endpackage

// File: rtl/vu_tick_gen.sv
// Free-running modulo-DIV counter with a one-cycle tick on DIV-1.
// Ports: clk_i, rst_i (sync, high), clr_i (hold at 0), tick_o.
module vu_tick_gen #(
  parameter int DIV = 1000,
  parameter int W   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/vu_sample_ctrl.sv
// Sample sequencer: tick -> ADC start/ready handshake -> register strobes.
// Ports: clock, reset, run, clear, adc_ready/adc_fault in;
//        adc_start, reg_*, busy, sticky flags, err_count out.
module vu_sample_ctrl
  import vu_pkg::*;
#(
  parameter int SAMPLE_DIV = VU_SAMPLE_DIV,
  parameter int DIV_WIDTH  = 16,
  parameter int TIMEOUT    = VU_ADC_TIMEOUT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    adc_ready,
  input  logic                    adc_fault,
  output logic                    adc_start,
  output logic                    reg_enable,
  output logic                    reg_load,
  output logic                    reg_error,
  output logic                    busy,
  output logic                    timeout_flag,
  output logic                    overrun_flag,
  output logic [VU_ERR_CNT_W-1:0] err_count
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [VU_ERR_CNT_W-1:0] CNT_MAX = '1;

  vu_ctrl_state_t          state_q;
  logic [TO_W-1:0]         to_cnt_q;
  logic                    err_q;
  logic                    timeout_q;
  logic                    overrun_q;
  logic [VU_ERR_CNT_W-1:0] err_cnt_q;

  logic tick;
  logic busy_w;
  logic to_set;
  logic ov_set;
  logic cnt_inc;

  vu_tick_gen #(
    .DIV (SAMPLE_DIV),
    .W   (DIV_WIDTH)
  ) u_tick (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  assign busy_w = (state_q == ST_START)
               || (state_q == ST_CONVERT)
               || (state_q == ST_LOAD);

  // A ready on the last convert cycle takes precedence over the timeout.
  assign to_set  = (state_q == ST_CONVERT) && !adc_ready
                && (to_cnt_q == TO_LAST);
  // A tick landing mid-conversion is dropped, only recorded.
  assign ov_set  = tick && busy_w;
  assign cnt_inc = (state_q == ST_LOAD) && err_q
                && (err_cnt_q != CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run) state_q <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!run)      state_q <= ST_IDLE;
          else if (tick) state_q <= ST_START;
        end
        ST_START: begin
          to_cnt_q <= '0;
          state_q  <= ST_CONVERT;
        end
        ST_CONVERT: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          if (adc_ready) begin
            err_q   <= adc_fault;
            state_q <= ST_LOAD;
          end else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= run ? ST_WAIT_TICK : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (clear) begin
        timeout_q <= 1'b0;
        overrun_q <= 1'b0;
        err_cnt_q <= '0;
      end else begin
        if (to_set)  timeout_q <= 1'b1;
        if (ov_set)  overrun_q <= 1'b1;
        if (cnt_inc) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign adc_start    = (state_q == ST_START);
  assign reg_enable   = (state_q == ST_LOAD);
  assign reg_load     = (state_q == ST_LOAD);
  assign reg_error    = (state_q == ST_LOAD) && err_q;
  assign busy         = busy_w;
  assign timeout_flag = timeout_q;
  assign overrun_flag = overrun_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_vu_sample_ctrl.sv
// Bench for vu_sample_ctrl: two instances (TIMEOUT 4 and 16),
// timestamp-based reference model plus directed literal checks.
module tb_vu_sample_ctrl;

  localparam int DIV = 8;
  localparam int TO0 = 4;
  localparam int TO1 = 16;
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_START = 2;
  localparam int P_CONV  = 3;
  localparam int P_LOAD  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run   = 1'b0;
  logic clear = 1'b0;
  logic [1:0] adc_ready = '0;
  logic [1:0] adc_fault = '0;
  logic [1:0] adc_start, reg_enable, reg_load, reg_error;
  logic [1:0] busy, timeout_flag, overrun_flag;
  logic [1:0][7:0] errc;

  int ncmp = 0;
  int nfail = 0;
  bit chk_en = 0;
  bit rnd_mode = 0;
  int tos[2] = '{TO0, TO1};
  int dly[2];
  bit flt[2];
  int cd[2];

  int ph[2];
  int t_run[2];
  int t_start[2];
  int m_cnt[2];
  bit m_err[2];
  bit m_to[2];
  bit m_ov[2];
  int cyc = 0;

  always #5 clock = ~clock;

  vu_sample_ctrl #(
    .SAMPLE_DIV(DIV), .DIV_WIDTH(16), .TIMEOUT(TO0)
  ) dut0 (
    .clock(clock), .reset(reset), .run(run), .clear(clear),
    .adc_ready(adc_ready[0]), .adc_fault(adc_fault[0]),
    .adc_start(adc_start[0]), .reg_enable(reg_enable[0]),
    .reg_load(reg_load[0]), .reg_error(reg_error[0]),
    .busy(busy[0]), .timeout_flag(timeout_flag[0]),
    .overrun_flag(overrun_flag[0]), .err_count(errc[0])
  );

  vu_sample_ctrl #(
    .SAMPLE_DIV(DIV), .DIV_WIDTH(16), .TIMEOUT(TO1)
  ) dut1 (
    .clock(clock), .reset(reset), .run(run), .clear(clear),
    .adc_ready(adc_ready[1]), .adc_fault(adc_fault[1]),
    .adc_start(adc_start[1]), .reg_enable(reg_enable[1]),
    .reg_load(reg_load[1]), .reg_error(reg_error[1]),
    .busy(busy[1]), .timeout_flag(timeout_flag[1]),
    .overrun_flag(overrun_flag[1]), .err_count(errc[1])
  );

  function automatic logic [14:0] bundle(int i);
    return {adc_start[i], reg_enable[i], reg_load[i], reg_error[i],
            busy[i], timeout_flag[i], overrun_flag[i], errc[i]};
  endfunction

  function automatic logic [14:0] expect_of(int i);
    logic ld;
    logic bz;
    ld = (ph[i] == P_LOAD);
    bz = (ph[i] == P_START) || (ph[i] == P_CONV) || ld;
    return {ph[i] == P_START, ld, ld, ld && m_err[i], bz,
            m_to[i], m_ov[i], 8'(m_cnt[i])};
  endfunction

  function automatic logic sig(int s);
    case (s)
      0: return adc_start[0];
      1: return reg_load[0];
      2: return adc_start[1];
      default: return reg_load[1];
    endcase
  endfunction

  task automatic lit(string nm, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_sig(int s, int bound, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sig(s) && n <= bound);
  endtask

  // Reference: a tick occurs every DIV cycles counted from the first
  // waiting cycle; a conversion times out TIMEOUT cycles after its start.
  task automatic model_step();
    int nph;
    bit tk;
    bit to_hit;
    bit inc;
    bit in_conv;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ph[i] = P_IDLE;
        m_err[i] = 0;
        m_to[i] = 0;
        m_ov[i] = 0;
        m_cnt[i] = 0;
      end else begin
        tk = (ph[i] != P_IDLE) && ((cyc - t_run[i]) % DIV == DIV - 1);
        in_conv = (ph[i] == P_START) || (ph[i] == P_CONV)
               || (ph[i] == P_LOAD);
        inc = (ph[i] == P_LOAD) && m_err[i];
        to_hit = 0;
        nph = ph[i];
        case (ph[i])
          P_IDLE: if (run) begin
            nph = P_WAIT;
            t_run[i] = cyc + 1;
          end
          P_WAIT: begin
            if (!run) nph = P_IDLE;
            else if (tk) nph = P_START;
          end
          P_START: begin
            t_start[i] = cyc;
            nph = P_CONV;
          end
          P_CONV: begin
            if (adc_ready[i]) begin
              nph = P_LOAD;
              m_err[i] = adc_fault[i];
            end else if (cyc - t_start[i] == tos[i]) begin
              nph = P_LOAD;
              m_err[i] = 1;
              to_hit = 1;
            end
          end
          default: nph = run ? P_WAIT : P_IDLE;
        endcase
        if (clear) begin
          m_to[i] = 0;
          m_ov[i] = 0;
          m_cnt[i] = 0;
        end else begin
          if (to_hit) m_to[i] = 1;
          if (tk && in_conv) m_ov[i] = 1;
          if (inc && m_cnt[i] < 255) m_cnt[i]++;
        end
        ph[i] = nph;
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (bundle(i) !== expect_of(i)) begin
          nfail++;
          $display("FAIL model_dut%0d cyc %0d: got %h expected %h",
                   i, cyc, bundle(i), expect_of(i));
        end
      end
    end
  end

  // ADC front-end emulation: ready arrives cd cycles after adc_start.
  initial forever begin
    bit r;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      r = 0;
      if (cd[i] > 0) begin
        cd[i]--;
        r = (cd[i] == 0);
      end
      if (adc_start[i] === 1'b1) begin
        cd[i] = rnd_mode ? int'($urandom_range(0, tos[i] + 2)) : dly[i];
      end
      if (rnd_mode && $urandom_range(0, 15) == 0) r = 1;
      adc_ready[i] = r;
      adc_fault[i] = r && (rnd_mode ? ($urandom_range(0, 3) == 0)
                                    : flt[i]);
    end
  end

  initial begin
    int n;
    dly[0] = 2;
    dly[1] = 2;
    flt[0] = 0;
    flt[1] = 0;
    repeat (3) @(negedge clock);
    chk_en = 1;
    lit("reset_outputs", int'(bundle(0)), 0);
    reset = 0;
    run = 1;

    wait_sig(0, 40, n);
    lit("first_start_lat", n, 9);
    wait_sig(1, 20, n);
    lit("nominal_load_lat", n, 3);
    lit("nominal_reg_error", int'(reg_error[0]), 0);
    wait_sig(0, 20, n);
    lit("load_to_next_start", n, 5);

    flt[0] = 1;
    wait_sig(1, 20, n);
    lit("fault_load_lat", n, 3);
    lit("fault_reg_error", int'(reg_error[0]), 1);
    @(negedge clock);
    lit("fault_err_count", int'(errc[0]), 1);

    flt[0] = 0;
    dly[0] = 0;
    wait_sig(0, 20, n);
    wait_sig(1, 20, n);
    lit("timeout_load_lat", n, 5);
    lit("timeout_reg_error", int'(reg_error[0]), 1);
    @(negedge clock);
    lit("timeout_flag_set", int'(timeout_flag[0]), 1);
    lit("timeout_err_count", int'(errc[0]), 2);

    clear = 1;
    @(negedge clock);
    clear = 0;
    lit("clear_status", int'({timeout_flag[0], overrun_flag[0], errc[0]}), 0);

    dly[0] = TO0;
    wait_sig(0, 20, n);
    wait_sig(1, 20, n);
    lit("late_ready_load_lat", n, 5);
    lit("late_ready_reg_error", int'(reg_error[0]), 0);
    @(negedge clock);
    lit("late_ready_no_timeout", int'(timeout_flag[0]), 0);

    dly[1] = 7;
    wait_sig(2, 20, n);
    wait_sig(3, 20, n);
    lit("overrun_load_lat", n, 8);
    lit("overrun_flag_set", int'(overrun_flag[1]), 1);
    dly[1] = 2;
    wait_sig(2, 20, n);
    lit("overrun_next_start", n, 8);

    dly[0] = 2;
    wait_sig(0, 20, n);
    @(negedge clock);
    run = 0;
    wait_sig(1, 20, n);
    lit("drop_load_lat", n, 2);
    wait_sig(0, 30, n);
    lit("drop_no_start", n, 31);
    lit("drop_idle_busy", int'(busy[0]), 0);

    flt[0] = 1;
    dly[0] = 1;
    run = 1;
    for (int k = 0; k < 300; k++) wait_sig(1, 20, n);
    @(negedge clock);
    lit("err_count_saturate", int'(errc[0]), 255);

    clear = 1;
    @(negedge clock);
    clear = 0;
    lit("clear_all", int'({timeout_flag[0], overrun_flag[0], errc[0]}), 0);

    wait_sig(1, 20, n);
    flt[0] = 0;
    dly[0] = 0;
    wait_sig(0, 20, n);
    @(negedge clock);
    lit("pre_reset_busy", int'(busy[0]), 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    lit("reset_mid_convert", int'(bundle(0)), 0);

    rnd_mode = 1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clock);
      if ($urandom_range(0, 149) == 0) run = ~run;
      clear = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 799) == 0);
    end
    @(negedge clock);
    reset = 0;
    clear = 0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
